popcount19_vecgen: RTL

POPCOUNT19_VECGEN -- requirements
Module: popcount19_vecgen

---
 rtl/popcount19_vecgen.sv | 97 +++++++++
 1 files changed

// File: rtl/popcount19_vecgen.sv
// Enumerates every 19-bit vector with popcount k in increasing order over a
// valid/ready stream; the successor is the next larger integer with equal popcount.
module popcount19_vecgen #(
    parameter int N = 19
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [4:0]   k,
    input  logic         abort,
    input  logic         vec_ready,
    output logic         vec_valid,
    output logic [N-1:0] vec,
    output logic         vec_last,
    output logic [16:0]  vec_idx,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic IDLE = 1'b0;
    localparam logic EMIT = 1'b1;
    localparam logic [N-1:0] ALL_ONES = '1;

    logic         state;
    logic [4:0]   k_q;
    logic [N-1:0] first_vec;
    logic [N-1:0] last_vec;
    logic [N-1:0] low_bit;
    logic [N-1:0] ripple;
    logic [N-1:0] next_vec;
    logic [4:0]   tz;

    // First vector has the k low bits set, last vector the k high bits set.
    assign first_vec = ~(ALL_ONES << k);
    assign last_vec  = ~(ALL_ONES >> k_q);

    assign vec_valid = (state == EMIT);
    assign busy      = (state == EMIT);
    assign vec_last  = vec_valid && (vec == last_vec);

    // Next value with equal popcount: add the lowest set bit, then refill the
    // displaced ones at the bottom. Dividing by the lowest set bit is a right
    // shift by its index, so no divider is needed. Never used on the last vector,
    // so the addition cannot carry out of N bits.
    always_comb begin
        tz = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                tz = 5'(i);
            end
        end
        low_bit  = vec & (-vec);
        ripple   = vec + low_bit;
        next_vec = ripple | (((ripple ^ vec) >> 2) >> tz);
    end

    // Two-state controller: abort wins over a simultaneous handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            k_q     <= '0;
            vec     <= '0;
            vec_idx <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    if (k > 5'd19) begin
                        err <= 1'b1;
                    end else begin
                        state   <= EMIT;
                        k_q     <= k;
                        vec     <= first_vec;
                        vec_idx <= '0;
                    end
                end
            end else begin
                if (abort) begin
                    state <= IDLE;
                end else if (vec_ready) begin
                    if (vec_last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        vec     <= next_vec;
                        vec_idx <= vec_idx + 17'd1;
                    end
                end
            end
        end
    end

endmodule
